axis_fifo: RTL and testbench



---
 rtl/axis_converter_lite_pkg_prm.sv | 8 +
 rtl/axis_if.sv | 8 +
 rtl/axis_fifo_mem.sv | 18 +
 rtl/axis_fifo.sv | 59 +++++
 tb/tb_axis_fifo.sv | 121 ++++++++++++
 5 files changed

// File: rtl/axis_converter_lite_pkg_prm.sv
// axis_converter_lite_pkg_prm: shared widths and sizes for the AXI-Lite to AXI-Stream path
package axis_converter_lite_pkg_prm;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXIS_FIFO_DEPTH = 16;
  function automatic bit is_pow2(int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/axis_if.sv
// axis_if: AXI-Stream tdata/tvalid/tready bundle with sink and source views
interface axis_if import axis_converter_lite_pkg_prm::*; ();
  logic [AXI_DATA_WIDTH-1:0] tdata;
  logic tvalid;
  logic tready;
  modport s_axis(input tdata, input tvalid, output tready);
  modport m_axis(output tdata, output tvalid, input tready);
endinterface

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: register array with one write port and an asynchronous read port
module axis_fifo_mem import axis_converter_lite_pkg_prm::*; #(
  parameter int DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                       aclk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]  wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [AXI_DATA_WIDTH-1:0]  rd_data
);
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  // storage is deliberately left unreset; only the pointers define validity
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/axis_fifo.sv
// axis_fifo: first-word-fall-through AXI-Stream FIFO; AXIS_FIFO_STATUS_EN adds fill_level/almost_full
module axis_fifo import axis_converter_lite_pkg_prm::*; #(
  parameter int DEPTH = AXIS_FIFO_DEPTH,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
  input  logic aclk,
  input  logic areset,
  axis_if.s_axis s_axis,
  axis_if.m_axis m_axis
`ifdef AXIS_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic almost_full
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
  if (!is_pow2(DEPTH) || DEPTH < 2 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_cfg
    $error("axis_fifo: DEPTH must be a power of two >= 2 and ALMOST_FULL_THRESH <= DEPTH");
  end
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count, count_next;
  logic push, pop;
  assign push = s_axis.tvalid & s_axis.tready;
  assign pop = m_axis.tvalid & m_axis.tready;
  assign count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  // handshake flags come from count_next so they are registered yet exact the cycle after any transfer
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      s_axis.tready <= 1'b0;
      m_axis.tvalid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count <= count_next;
      s_axis.tready <= count_next != FULL;
      m_axis.tvalid <= count_next != '0;
    end
  end
  axis_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .aclk(aclk),
    .wr_en(push & ~areset),
    .wr_addr(wr_ptr),
    .wr_data(s_axis.tdata),
    .rd_addr(rd_ptr),
    .rd_data(m_axis.tdata)
  );
`ifdef AXIS_FIFO_STATUS_EN
  localparam logic [PTR_W:0] AF = (PTR_W + 1)'(ALMOST_FULL_THRESH);
  assign fill_level = count;
  // almost_full tracks the post-edge fill so it lines up with fill_level
  always_ff @(posedge aclk) begin
    almost_full <= areset ? 1'b0 : count_next >= AF;
  end
`endif
endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: queue-model scoreboard bench for axis_fifo with directed and random traffic
module tb_axis_fifo;
  import axis_converter_lite_pkg_prm::*;
  localparam int DEPTH = AXIS_FIFO_DEPTH;
  logic aclk = 1'b0;
  logic areset;
  int checks = 0;
  int errors = 0;
  logic [AXI_DATA_WIDTH-1:0] q[$];
  logic pv;
  logic [AXI_DATA_WIDTH-1:0] pd;
  axis_if s_if();
  axis_if m_if();
`ifdef AXIS_FIFO_STATUS_EN
  logic [$clog2(DEPTH):0] fill_level;
  logic almost_full;
`endif
  axis_fifo #(.DEPTH(DEPTH)) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axis(s_if.s_axis),
    .m_axis(m_if.m_axis)
`ifdef AXIS_FIFO_STATUS_EN
    ,
    .fill_level(fill_level),
    .almost_full(almost_full)
`endif
  );
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: runs at negedge, judges the edge just passed from the outputs held across it
  initial begin
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        q.delete();
        chk("rst_tvalid", 64'(m_if.tvalid), 64'(0));
        chk("rst_tready", 64'(s_if.tready), 64'(0));
`ifdef AXIS_FIFO_STATUS_EN
        chk("rst_fill_level", 64'(fill_level), 64'(0));
        chk("rst_almost_full", 64'(almost_full), 64'(0));
`endif
      end else begin
        if (pv && m_if.tready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_underflow: got a pop with data %0h, required no pop (model empty) at %0t", pd, $time);
          end else chk("pop_data", 64'(pd), 64'(q.pop_front()));
        end
        chk("tvalid", 64'(m_if.tvalid), 64'(q.size() != 0));
        chk("tready", 64'(s_if.tready), 64'(q.size() != DEPTH));
        if (q.size() != 0) chk("tdata_head", 64'(m_if.tdata), 64'(q[0]));
`ifdef AXIS_FIFO_STATUS_EN
        chk("fill_level", 64'(fill_level), 64'(q.size()));
        chk("almost_full", 64'(almost_full), 64'(q.size() >= DEPTH - 2));
`endif
      end
      pv = m_if.tvalid;
      pd = m_if.tdata;
    end
  end

  // driver: applies one cycle of stimulus and records words that the FIFO is about to accept
  task automatic step(input logic rst, input logic sv, input logic [AXI_DATA_WIDTH-1:0] sd, input logic mr);
    @(negedge aclk);
    #1;
    areset = rst;
    s_if.tvalid = sv;
    s_if.tdata = sd;
    m_if.tready = mr;
    if (!rst && sv && s_if.tready) q.push_back(sd);
  endtask

  initial begin
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    m_if.tready = 1'b0;
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
    repeat (10) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    repeat (2) step(1'b0, 1'b1, 32'h0000_0011, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
    repeat (DEPTH + 4) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 32'(i), 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'h0000_0bad, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int b = 0; b < 16; b++) begin
      int pw, pr;
      pw = $urandom_range(1, 9);
      pr = $urandom_range(1, 9);
      repeat (200) step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < pw, $urandom, $urandom_range(0, 9) < pr);
    end
    repeat (DEPTH + 8) step(1'b0, 1'b0, '0, 1'b1);
    @(negedge aclk);
    #2;
    chk("final_empty", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
